// File: rtl/cobra_mem_arbiter.sv
// Single-port system RAM arbiter between the Z80 core and the video scanout fetcher.
// Define COBRA_MEM_ARB_STATS_EN to add the stat_clr / stat_cpu_stall / stat_vid_fetch counters.
module cobra_mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_mreq,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_wait_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_mreq,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata
`ifdef COBRA_MEM_ARB_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_cpu_stall,
    output logic [15:0]   stat_vid_fetch
`endif
);

    typedef enum logic [1:0] {
        C_IDLE,
        C_GRANT,
        C_HOLD
    } cpu_state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    cpu_state_t    state, state_nxt;
    logic [3:0]    streak, streak_nxt;
    logic          vid_inflight;
    logic          cpu_is_rd;
    logic [DW-1:0] vid_data_q;
    logic          cpu_req, cpu_cand, vid_cand;
    logic          grant_cpu, grant_vid;

    // Grants are suppressed during reset so the RAM sees no strobes.
    assign cpu_req  = cpu_mreq & (cpu_rd | cpu_wr);
    assign cpu_cand = cpu_req & (state == C_IDLE) & ~reset;
    assign vid_cand = vid_req & ~vid_inflight & ~reset;

    assign grant_vid = vid_cand & (~cpu_cand | (streak < STREAK_MAX));
    assign grant_cpu = cpu_cand & ~grant_vid;

    assign cpu_wait_n = reset | ~(cpu_req & (state != C_HOLD));
    assign vid_ack    = vid_inflight & ~reset;
    assign vid_data   = vid_ack ? mem_rdata : vid_data_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_nxt  = state;
        streak_nxt = streak;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_mreq   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;

        unique case (state)
            C_IDLE:  if (grant_cpu) state_nxt = C_GRANT;
            C_GRANT: state_nxt = cpu_req ? C_HOLD : C_IDLE;
            C_HOLD:  if (!cpu_req) state_nxt = C_IDLE;
            default: state_nxt = C_IDLE;
        endcase

        // Streak only builds while the CPU is actually waiting behind video.
        if (grant_cpu || !cpu_cand)
            streak_nxt = '0;
        else if (grant_vid && streak < STREAK_MAX)
            streak_nxt = streak + 4'd1;

        if (grant_vid) begin
            mem_addr = vid_addr;
            mem_mreq = 1'b1;
            mem_rd   = 1'b1;
        end else if (grant_cpu) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_mreq  = 1'b1;
            mem_rd    = cpu_rd;
            mem_wr    = cpu_wr;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state        <= C_IDLE;
            streak       <= '0;
            vid_inflight <= 1'b0;
            vid_data_q   <= '0;
            cpu_rdata    <= '0;
            cpu_is_rd    <= 1'b0;
        end else begin
            state        <= state_nxt;
            streak       <= streak_nxt;
            vid_inflight <= grant_vid;
            if (vid_inflight)
                vid_data_q <= mem_rdata;
            if (grant_cpu)
                cpu_is_rd <= cpu_rd;
            // RAM data for the CPU grant is valid while in C_GRANT, even if the request already fell.
            if (state == C_GRANT && cpu_is_rd)
                cpu_rdata <= mem_rdata;
        end
    end

`ifdef COBRA_MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stat_cpu_stall <= '0;
            stat_vid_fetch <= '0;
        end else begin
            if (!cpu_wait_n && stat_cpu_stall != 16'hFFFF)
                stat_cpu_stall <= stat_cpu_stall + 16'd1;
            if (vid_ack && stat_vid_fetch != 16'hFFFF)
                stat_vid_fetch <= stat_vid_fetch + 16'd1;
        end
    end
`endif

endmodule
